// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with operand forwarding, load-use stall, data-bus wait and trap flush sequencing.
module hazard_ctrl #(
  parameter int TRAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemReadE,
  input  logic       PCSrcE,
  input  logic       TrapReqM,
  input  logic       DMemReqM,
  input  logic       DMemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       EnE,
  output logic       EnM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       TrapBusy
);
  typedef enum logic [1:0] {RUN, MEMWAIT, TRAP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(TRAP_CYCLES - 1);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lw_stall, mem_wait;
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] rdm, input logic wm,
                                     input logic [4:0] rdw, input logic ww);
    return (wm && rdm != 5'd0 && rdm == rs) ? 2'b10 :
           (ww && rdw != 5'd0 && rdw == rs) ? 2'b01 : 2'b00;
  endfunction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    StallF    = 1'b0;
    StallD    = 1'b0;
    EnE       = 1'b1;
    EnM       = 1'b1;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    TrapBusy  = 1'b0;
    mem_wait  = DMemReqM && !DMemReadyM;
    lw_stall  = MemReadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    ForwardAE = fwd(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    case (state_q)
      RUN: begin
        if (TrapReqM) begin
          {FlushD, FlushE, FlushM} = 3'b111;
          state_d = (TRAP_CYCLES == 1) ? RUN : TRAP;
          cnt_d   = CNT_INIT;
        end else if (mem_wait) begin
          {StallF, StallD, EnE, EnM, FlushM} = 5'b11001;
          state_d = MEMWAIT;
        end else if (PCSrcE) begin
          {FlushD, FlushE} = 2'b11;
        end else if (lw_stall) begin
          {StallF, StallD, FlushE} = 3'b111;
        end
      end
      MEMWAIT: begin
        if (!DMemReadyM) {StallF, StallD, EnE, EnM, FlushM} = 5'b11001;
        else state_d = RUN;
      end
      TRAP: begin
        {FlushD, FlushE, FlushM, TrapBusy} = 4'b1111;
        state_d = (cnt_q == 4'd0) ? RUN : TRAP;
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
    // Reset must silence outputs combinationally, not just at the next edge.
    if (!rst) begin
      {StallF, StallD, FlushD, FlushE, FlushM, TrapBusy} = 6'b0;
      {EnE, EnM} = 2'b11;
      ForwardAE  = 2'b00;
      ForwardBE  = 2'b00;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, directed multi-cycle sequences and randomized run against a behavioural model.
module tb_hazard_ctrl;
  localparam int TC = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MemReadE, PCSrcE, TrapReqM, DMemReqM, DMemReadyM;
  logic       StallF, StallD, EnE, EnM, FlushD, FlushE, FlushM, TrapBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [11:0] act;
  int vecs = 0;
  int errs = 0;
  logic m_wait = 1'b0;
  int   m_busy = 0;

  hazard_ctrl #(.TRAP_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
    .PCSrcE(PCSrcE), .TrapReqM(TrapReqM), .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .StallF(StallF), .StallD(StallD), .EnE(EnE), .EnM(EnM), .FlushD(FlushD), .FlushE(FlushE),
    .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .TrapBusy(TrapBusy)
  );

  always #5 clk = ~clk;
  assign act = {StallF, StallD, EnE, EnM, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, TrapBusy};

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, mre, pcs;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [11:0] exp);
    #2;
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, MemReadE, PCSrcE, TrapReqM, DMemReqM, DMemReadyM} = '0;
  endtask

  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected output bundle from the current abstract mode (waiting / trap cycles left) and inputs.
  function automatic logic [11:0] model_out();
    logic        lw;
    logic [11:0] fw;
    lw = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    fw = {7'b0, mfwd(Rs1E), mfwd(Rs2E), 1'b0};
    if (!rst) return 12'h300;
    if (m_busy > 0) return 12'h3E1 | fw;
    if (m_wait) return (DMemReadyM ? 12'h300 : 12'hC20) | fw;
    if (TrapReqM) return 12'h3E0 | fw;
    if (DMemReqM && !DMemReadyM) return 12'hC20 | fw;
    if (PCSrcE) return 12'h3C0 | fw;
    if (lw) return 12'hF40 | fw;
    return 12'h300 | fw;
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_wait = 1'b0;
      m_busy = 0;
    end else if (m_busy > 0) m_busy--;
    else if (m_wait) m_wait = !DMemReadyM;
    else if (TrapReqM) m_busy = (TC == 1) ? 0 : TC;
    else if (DMemReqM && !DMemReadyM) m_wait = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 12'h310};
    tbl[1]  = '{0, 0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 12'h308};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 12'h300};
    tbl[3]  = '{0, 0, 0, 9, 0, 9, 9, 0, 1, 0, 0, 12'h302};
    tbl[4]  = '{0, 0, 0, 9, 0, 9, 9, 1, 1, 0, 0, 12'h304};
    tbl[5]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 12'hF40};
    tbl[6]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 12'h300};
    tbl[7]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 12'h3C0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 12'h300};
    tbl[9]  = '{7, 3, 0, 0, 7, 0, 0, 0, 0, 1, 0, 12'hF40};
    tbl[10] = '{0, 0, 12, 12, 0, 12, 12, 1, 1, 0, 0, 12'h314};
    tbl[11] = '{0, 0, 3, 0, 0, 19, 3, 1, 1, 0, 0, 12'h308};
    clr_in();
    Rs1E = 5; RdM = 5; RegWriteM = 1; TrapReqM = 1; DMemReqM = 1;
    #1 chk("reset_force", 12'h300);
    @(negedge clk) chk("reset_hold", 12'h300);
    @(negedge clk) rst = 1'b1; clr_in();
    chk("idle", 12'h300);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk) clr_in();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} =
        {tbl[i].rs1d, tbl[i].rs2d, tbl[i].rs1e, tbl[i].rs2e, tbl[i].rde, tbl[i].rdm, tbl[i].rdw};
      {RegWriteM, RegWriteW, MemReadE, PCSrcE} = {tbl[i].rwm, tbl[i].rww, tbl[i].mre, tbl[i].pcs};
      chk($sformatf("table%0d", i), tbl[i].exp);
    end
    @(negedge clk) clr_in(); DMemReqM = 1;
    chk("mw1", 12'hC20);
    @(negedge clk) TrapReqM = 1;
    chk("mw2_trap_ignored", 12'hC20);
    @(negedge clk) TrapReqM = 0;
    chk("mw3", 12'hC20);
    @(negedge clk) DMemReadyM = 1;
    chk("mw_ready", 12'h300);
    @(negedge clk) clr_in();
    chk("mw_after", 12'h300);
    @(negedge clk) TrapReqM = 1;
    chk("trap_accept", 12'h3E0);
    @(negedge clk) TrapReqM = 0;
    chk("trap_busy1", 12'h3E1);
    @(negedge clk) chk("trap_busy2", 12'h3E1);
    @(negedge clk) chk("trap_done", 12'h300);
    @(negedge clk) TrapReqM = 1;
    chk("rt_accept", 12'h3E0);
    @(negedge clk) TrapReqM = 0;
    chk("rt_busy", 12'h3E1);
    #1 rst = 1'b0;
    chk("rt_reset_now", 12'h300);
    @(negedge clk) chk("rt_reset_hold", 12'h300);
    @(negedge clk) rst = 1'b1;
    chk("rt_release1", 12'h300);
    @(negedge clk) chk("rt_release2", 12'h300);
    m_wait = 1'b0;
    m_busy = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      MemReadE   = 1'($urandom_range(0, 1)); PCSrcE    = 1'($urandom_range(0, 1));
      TrapReqM   = ($urandom_range(0, 11) == 0);
      DMemReqM   = ($urandom_range(0, 2) == 0);
      DMemReadyM = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 39) != 0);
      chk("random", model_out());
      model_step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
